// File: rtl/trap_ctrl_pkg.sv
// trap_ctrl_pkg: shared definitions for the machine-mode trap controller.
//   - CSR addresses, mstatus field positions, mcause codes
//   - privilege encodings, decoded opcode values, FSM state encoding
//   - small decode helpers used by the controller
package trap_ctrl_pkg;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MIE     = 12'h304;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MTVAL   = 12'h343;
    localparam logic [11:0] CSR_MIP     = 12'h344;

    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_LO = 11;
    localparam int MSTATUS_MPP_HI = 12;

    // External interrupt line i lives at mie/mip bit IRQ_BASE+i.
    localparam int IRQ_BASE = 16;

    localparam logic [4:0] CAUSE_MISALIGN = 5'd0;
    localparam logic [4:0] CAUSE_ILLEGAL  = 5'd2;
    localparam logic [4:0] CAUSE_BREAK    = 5'd3;
    localparam logic [4:0] CAUSE_ECALL_U  = 5'd8;
    localparam logic [4:0] CAUSE_ECALL_M  = 5'd11;

    localparam logic [1:0] PRIV_U = 2'b00;
    localparam logic [1:0] PRIV_M = 2'b11;

    localparam logic [7:0] OP_ECALL   = 8'd1;
    localparam logic [7:0] OP_EBREAK  = 8'd2;
    localparam logic [7:0] OP_MRET    = 8'd3;
    localparam logic [7:0] OP_ILLEGAL = 8'd4;
    localparam logic [7:0] OP_CSRRW   = 8'd5;
    localparam logic [7:0] OP_CSRRS   = 8'd6;
    localparam logic [7:0] OP_CSRRC   = 8'd7;
    localparam logic [7:0] OP_CSRRWI  = 8'd8;
    localparam logic [7:0] OP_CSRRSI  = 8'd9;
    localparam logic [7:0] OP_CSRRCI  = 8'd10;

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_REDIRECT = 1'b1
    } state_t;

    function automatic logic is_csr_op(input logic [7:0] op);
        return op inside {OP_CSRRW, OP_CSRRS, OP_CSRRC, OP_CSRRWI, OP_CSRRSI, OP_CSRRCI};
    endfunction

    function automatic logic csr_implemented(input logic [11:0] addr);
        return addr inside {CSR_MSTATUS, CSR_MIE, CSR_MTVEC, CSR_MEPC,
                            CSR_MCAUSE, CSR_MTVAL, CSR_MIP};
    endfunction

    // Only U and M exist, so MPP may only ever hold one of those two.
    function automatic logic mpp_legal(input logic [1:0] mpp);
        return (mpp == PRIV_U) || (mpp == PRIV_M);
    endfunction

endpackage

// File: rtl/trap_ctrl_if.sv
// trap_ctrl_if: fetch-redirect handshake between the trap controller and fetch.
//   valid  - redirect target is valid (held until accepted)
//   pc     - redirect target, stable while valid is high
//   ready  - fetch accepts the redirect
// master = trap controller (source), slave = fetch (sink).
interface trap_ctrl_if #(
    parameter int XLEN = 32
) ();
    logic            valid;
    logic [XLEN-1:0] pc;
    logic            ready;

    modport master (output valid, output pc, input ready);
    modport slave  (input valid, input pc, output ready);
endinterface

// File: rtl/trap_prio_enc.sv
// trap_prio_enc: combinational trap priority encoder.
//   irq_pend     in  enabled, pending interrupt lines (already gated)
//   exc_mis      in  instruction address misaligned
//   exc_ill      in  illegal instruction
//   exc_break    in  EBREAK
//   exc_ecall    in  ECALL
//   priv_u       in  current mode is U (selects ECALL cause)
//   trap_valid   out some trap is taken
//   is_interrupt out the taken trap is an interrupt
//   cause        out mcause code (interrupts: line index + 16)
module trap_prio_enc
    import trap_ctrl_pkg::*;
#(
    parameter int NUM_IRQ = 4
) (
    input  logic [NUM_IRQ-1:0] irq_pend,
    input  logic               exc_mis,
    input  logic               exc_ill,
    input  logic               exc_break,
    input  logic               exc_ecall,
    input  logic               priv_u,
    output logic               trap_valid,
    output logic               is_interrupt,
    output logic [4:0]         cause
);

    always_comb begin
        trap_valid   = 1'b0;
        is_interrupt = 1'b0;
        cause        = CAUSE_MISALIGN;
        if (|irq_pend) begin
            trap_valid   = 1'b1;
            is_interrupt = 1'b1;
            // Scan downward so the lowest pending index is the last assignment.
            for (int i = NUM_IRQ - 1; i >= 0; i--) begin
                if (irq_pend[i]) cause = 5'(IRQ_BASE + i);
            end
        end else if (exc_mis) begin
            trap_valid = 1'b1;
            cause      = CAUSE_MISALIGN;
        end else if (exc_ill) begin
            trap_valid = 1'b1;
            cause      = CAUSE_ILLEGAL;
        end else if (exc_break) begin
            trap_valid = 1'b1;
            cause      = CAUSE_BREAK;
        end else if (exc_ecall) begin
            trap_valid = 1'b1;
            cause      = priv_u ? CAUSE_ECALL_U : CAUSE_ECALL_M;
        end
    end

endmodule

// File: rtl/trap_ctrl.sv
// trap_ctrl: machine-mode trap controller beside the execute stage.
// Resolves exceptions and NUM_IRQ level interrupts, keeps mstatus/mie/mtvec/
// mepc/mcause/mtval/mip, and redirects fetch on trap entry and MRET.
// Ports:
//   clk_i, rst_n_i (sync, active-low)
//   en_i, pc_i, inst_i, inst_addr_mis_i, bad_addr_i : instruction in execute
//   csr_addr_i, csr_wr_en_i, csr_data_i, csr_data_o : CSR access (read is comb)
//   irq_i                                           : level interrupt lines
//   flush_o, stall_o, priv_o                        : pipeline control / mode
//   redir (trap_ctrl_if.master)                     : fetch redirect handshake
// Optional feature: define TRAP_VECTORED_EN for vectored interrupt targets
// (mtvec mode 1 sends interrupt i to base + 4*(i+16)).
module trap_ctrl
    import trap_ctrl_pkg::*;
#(
    parameter int              XLEN      = 32,
    parameter int              NUM_IRQ   = 4,
    parameter logic [XLEN-1:0] MTVEC_RST = '0
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               en_i,
    input  logic [XLEN-1:0]    pc_i,
    input  logic [7:0]         inst_i,
    input  logic               inst_addr_mis_i,
    input  logic [XLEN-1:0]    bad_addr_i,
    input  logic [11:0]        csr_addr_i,
    input  logic               csr_wr_en_i,
    input  logic [XLEN-1:0]    csr_data_i,
    input  logic [NUM_IRQ-1:0] irq_i,
    output logic [XLEN-1:0]    csr_data_o,
    output logic               flush_o,
    output logic               stall_o,
    output logic [1:0]         priv_o,
    trap_ctrl_if.master        redir
);

    localparam logic [XLEN-1:0] PC_MASK = ~XLEN'(1);

    state_t               state_q, state_d;
    logic [1:0]           priv_q;
    logic                 mst_mie_q, mst_mpie_q;
    logic [1:0]           mst_mpp_q;
    logic [NUM_IRQ-1:0]   mie_q, mip_q;
    logic [XLEN-1:2]      mtvec_base_q;
`ifdef TRAP_VECTORED_EN
    logic                 mtvec_mode_q;
`endif
    logic [XLEN-1:0]      mepc_q, mcause_q, mtval_q, redir_pc_q;

    logic               act, priv_u, csr_op, exc_ill, mret_ok, take, csr_wr;
    logic [NUM_IRQ-1:0] irq_pend;
    logic               trap_valid, is_int;
    logic [4:0]         cause;
    logic [XLEN-1:0]    trap_base, trap_tgt;

    // Execute-stage decode: everything is gated so nothing is seen outside IDLE.
    assign act    = en_i && (state_q == ST_IDLE);
    assign priv_u = (priv_q == PRIV_U);
    assign csr_op = is_csr_op(inst_i);

    assign exc_ill = act && ( (inst_i == OP_ILLEGAL)
                           || (csr_op && priv_u && (csr_addr_i[9:8] != 2'b00))
                           || (csr_wr_en_i && (csr_addr_i[11:10] == 2'b11))
                           || (csr_op && !csr_implemented(csr_addr_i))
                           || ((inst_i == OP_MRET) && priv_u) );

    // In U mode interrupts are always globally enabled; in M mode MIE decides.
    assign irq_pend = (mip_q & mie_q) & {NUM_IRQ{act && (priv_u || mst_mie_q)}};

    trap_prio_enc #(.NUM_IRQ(NUM_IRQ)) u_prio (
        .irq_pend     (irq_pend),
        .exc_mis      (act && inst_addr_mis_i),
        .exc_ill      (exc_ill),
        .exc_break    (act && (inst_i == OP_EBREAK)),
        .exc_ecall    (act && (inst_i == OP_ECALL)),
        .priv_u       (priv_u),
        .trap_valid   (trap_valid),
        .is_interrupt (is_int),
        .cause        (cause)
    );

    assign mret_ok = act && (inst_i == OP_MRET) && !priv_u;
    assign take    = trap_valid || mret_ok;
    assign csr_wr  = act && csr_wr_en_i && !take;

    assign trap_base = {mtvec_base_q, 2'b00};
`ifdef TRAP_VECTORED_EN
    assign trap_tgt = (mtvec_mode_q && is_int)
                    ? trap_base + {{(XLEN-7){1'b0}}, cause, 2'b00}
                    : trap_base;
`else
    assign trap_tgt = trap_base;
`endif

    assign flush_o   = take;
    assign priv_o    = priv_q;
    assign redir.pc  = redir_pc_q;

    always_comb begin
        csr_data_o = '0;
        case (csr_addr_i)
            CSR_MSTATUS: begin
                csr_data_o[MSTATUS_MIE]                     = mst_mie_q;
                csr_data_o[MSTATUS_MPIE]                    = mst_mpie_q;
                csr_data_o[MSTATUS_MPP_HI:MSTATUS_MPP_LO]   = mst_mpp_q;
            end
            CSR_MIE:    csr_data_o[IRQ_BASE +: NUM_IRQ] = mie_q;
            CSR_MIP:    csr_data_o[IRQ_BASE +: NUM_IRQ] = mip_q;
`ifdef TRAP_VECTORED_EN
            CSR_MTVEC:  csr_data_o = {mtvec_base_q, 1'b0, mtvec_mode_q};
`else
            CSR_MTVEC:  csr_data_o = {mtvec_base_q, 2'b00};
`endif
            CSR_MEPC:   csr_data_o = mepc_q;
            CSR_MCAUSE: csr_data_o = mcause_q;
            CSR_MTVAL:  csr_data_o = mtval_q;
            default:    csr_data_o = '0;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    // FSM next state and handshake outputs
    always_comb begin
        state_d     = state_q;
        stall_o     = 1'b0;
        redir.valid = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (take) state_d = ST_REDIRECT;
            end
            ST_REDIRECT: begin
                stall_o     = 1'b1;
                redir.valid = 1'b1;
                if (redir.ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // CSR state, trap entry and MRET return
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            priv_q       <= PRIV_M;
            mst_mie_q    <= 1'b0;
            mst_mpie_q   <= 1'b0;
            mst_mpp_q    <= PRIV_M;
            mie_q        <= '0;
            mip_q        <= '0;
            mtvec_base_q <= MTVEC_RST[XLEN-1:2];
`ifdef TRAP_VECTORED_EN
            mtvec_mode_q <= (MTVEC_RST[1:0] == 2'b01);
`endif
            mepc_q       <= '0;
            mcause_q     <= '0;
            mtval_q      <= '0;
            redir_pc_q   <= '0;
        end else begin
            mip_q <= irq_i;

            if (csr_wr) begin
                case (csr_addr_i)
                    CSR_MSTATUS: begin
                        mst_mie_q  <= csr_data_i[MSTATUS_MIE];
                        mst_mpie_q <= csr_data_i[MSTATUS_MPIE];
                        if (mpp_legal(csr_data_i[MSTATUS_MPP_HI:MSTATUS_MPP_LO]))
                            mst_mpp_q <= csr_data_i[MSTATUS_MPP_HI:MSTATUS_MPP_LO];
                    end
                    CSR_MIE: mie_q <= csr_data_i[IRQ_BASE +: NUM_IRQ];
                    CSR_MTVEC: begin
                        mtvec_base_q <= csr_data_i[XLEN-1:2];
`ifdef TRAP_VECTORED_EN
                        // Mode 2/3 are reserved: leave the current mode alone.
                        if (!csr_data_i[1]) mtvec_mode_q <= csr_data_i[0];
`endif
                    end
                    CSR_MEPC:   mepc_q   <= csr_data_i & PC_MASK;
                    CSR_MCAUSE: mcause_q <= csr_data_i;
                    CSR_MTVAL:  mtval_q  <= csr_data_i;
                    default: ;
                endcase
            end

            if (trap_valid) begin
                mepc_q     <= pc_i & PC_MASK;
                mcause_q   <= {is_int, {(XLEN-6){1'b0}}, cause};
                mtval_q    <= (!is_int && (cause == CAUSE_MISALIGN)) ? bad_addr_i : '0;
                mst_mpie_q <= mst_mie_q;
                mst_mie_q  <= 1'b0;
                mst_mpp_q  <= priv_q;
                priv_q     <= PRIV_M;
                redir_pc_q <= trap_tgt;
            end else if (mret_ok) begin
                priv_q     <= mst_mpp_q;
                mst_mie_q  <= mst_mpie_q;
                mst_mpie_q <= 1'b1;
                mst_mpp_q  <= PRIV_U;
                redir_pc_q <= mepc_q;
            end
        end
    end

endmodule
